// File: rtl/uart_frame_host.sv
// Host-side frame initiator: packs ina/inb/rin, sends it LSB byte first over a UART byte
// interface, then waits for the one-byte response. Optional macro RESP_TIMEOUT_EN bounds the wait.
module uart_frame_host #(
  parameter int unsigned D       = 3,
  parameter int unsigned M       = 16,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   start,
  input  logic [D-1:0]           ina,
  input  logic [D-1:0]           inb,
  input  logic [D*(D-1)/2-1:0]   rin,
  output logic [7:0]             TxData,
  output logic                   TxEn,
  input  logic                   TxDone,
  output logic                   RxEn,
  input  logic [7:0]             RxData,
  input  logic                   RxDone,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             result,
  output logic                   timeout
);

  localparam int unsigned NBYTES = M / 8;
  localparam int unsigned IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, NEXT, WAIT_RX, DONE} state_t;

  state_t        state, state_d;
  logic [M-1:0]  frame, frame_d;
  logic [IW-1:0] idx, idx_d;
  logic [7:0]    tx_data, tx_data_d;
  logic          tx_en, tx_en_d;
  logic          rx_en, rx_en_d;
  logic          busy_r, busy_d;
  logic          done_r, done_d;
  logic [7:0]    result_r, result_d;
  logic          timeout_r, timeout_d;

`ifdef RESP_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt, cnt_d;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) cnt <= '0;
    else        cnt <= cnt_d;
  end
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      frame     <= '0;
      idx       <= '0;
      tx_data   <= '0;
      tx_en     <= 1'b0;
      rx_en     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      result_r  <= '0;
      timeout_r <= 1'b0;
    end else begin
      state     <= state_d;
      frame     <= frame_d;
      idx       <= idx_d;
      tx_data   <= tx_data_d;
      tx_en     <= tx_en_d;
      rx_en     <= rx_en_d;
      busy_r    <= busy_d;
      done_r    <= done_d;
      result_r  <= result_d;
      timeout_r <= timeout_d;
    end
  end

  // TxData is loaded on entry to LOAD so it is stable one cycle before TxEn rises.
  always_comb begin
    state_d   = state;
    frame_d   = frame;
    idx_d     = idx;
    tx_data_d = tx_data;
    tx_en_d   = tx_en;
    rx_en_d   = rx_en;
    busy_d    = busy_r;
    done_d    = 1'b0;
    result_d  = result_r;
    timeout_d = 1'b0;
`ifdef RESP_TIMEOUT_EN
    cnt_d     = cnt;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          frame_d   = M'({rin, inb, ina});
          tx_data_d = frame_d[7:0];
          busy_d    = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        tx_en_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (TxDone) begin
          tx_en_d = 1'b0;
          if (idx == LAST) begin
            rx_en_d = 1'b1;
            state_d = WAIT_RX;
`ifdef RESP_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            idx_d   = idx + 1'b1;
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        tx_data_d = frame[{idx, 3'b000} +: 8];
        state_d   = LOAD;
      end
      WAIT_RX: begin
        if (RxDone) begin
          result_d = RxData;
          rx_en_d  = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end
`ifdef RESP_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          rx_en_d   = 1'b0;
          busy_d    = 1'b0;
          idx_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
`endif
      end
      DONE: begin
        busy_d  = 1'b0;
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign TxData  = tx_data;
  assign TxEn    = tx_en;
  assign RxEn    = rx_en;
  assign busy    = busy_r;
  assign done    = done_r;
  assign result  = result_r;
  assign timeout = timeout_r;

endmodule

// File: tb/tb_uart_frame_host.sv
// Directed bench for uart_frame_host (D=3, M=16, TIMEOUT=16): frame bytes, response,
// ignored starts/strobes, mid-transaction reset and the response wait limit.
module tb_uart_frame_host;

  logic       Clk;
  logic       Rst_n;
  logic       start;
  logic [2:0] ina;
  logic [2:0] inb;
  logic [2:0] rin;
  logic [7:0] TxData;
  logic       TxEn;
  logic       TxDone;
  logic       RxEn;
  logic [7:0] RxData;
  logic       RxDone;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       timeout;

  int          vectors;
  int          miscompares;
  int unsigned cyc;

  uart_frame_host #(.D(3), .M(16), .TIMEOUT(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .start(start), .ina(ina), .inb(inb), .rin(rin),
    .TxData(TxData), .TxEn(TxEn), .TxDone(TxDone), .RxEn(RxEn), .RxData(RxData),
    .RxDone(RxDone), .busy(busy), .done(done), .result(result), .timeout(timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tx_en();
    int n;
    n = 0;
    while (TxEn !== 1'b1 && n < 50) begin
      @(negedge Clk);
      n++;
    end
  endtask

  // Serve one byte: TxDone is returned one cycle after TxEn is seen high.
  task automatic serve_tx(input logic [7:0] exp, input bit poke, input bit collide, input string tag);
    wait_tx_en();
    chk({tag, " tx_en rise"}, 32'(TxEn), 1);
    chk({tag, " tx_data"}, 32'(TxData), 32'(exp));
    if (poke) begin
      start = 1'b1;
      ina   = 3'b000;
      inb   = 3'b111;
    end
    @(negedge Clk);
    start = 1'b0;
    chk({tag, " tx_en held"}, 32'(TxEn), 1);
    chk({tag, " tx_data held"}, 32'(TxData), 32'(exp));
    TxDone = 1'b1;
    if (collide) begin
      RxDone = 1'b1;
      RxData = 8'hAA;
    end
    @(negedge Clk);
    TxDone = 1'b0;
    RxDone = 1'b0;
    RxData = 8'h00;
    chk({tag, " tx_en drop"}, 32'(TxEn), 0);
  endtask

  task automatic respond(input logic [7:0] data, input string tag);
    int n;
    n = 0;
    while (RxEn !== 1'b1 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    chk({tag, " rx_en"}, 32'(RxEn), 1);
    @(negedge Clk);
    RxData = data;
    RxDone = 1'b1;
    @(negedge Clk);
    RxDone = 1'b0;
    RxData = 8'h00;
  endtask

  task automatic kick(input logic [2:0] a, input logic [2:0] b, input logic [2:0] r);
    ina   = a;
    inb   = b;
    rin   = r;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  initial begin
    int unsigned c0;
    int          extra_done;
    int          extra_tx;
    int          bad;
    vectors     = 0;
    miscompares = 0;
    Rst_n  = 1'b0;
    start  = 1'b0;
    ina    = '0;
    inb    = '0;
    rin    = '0;
    TxDone = 1'b0;
    RxDone = 1'b0;
    RxData = '0;
    @(negedge Clk);
    @(negedge Clk);
    chk("reset tx_en", 32'(TxEn), 0);
    chk("reset rx_en", 32'(RxEn), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset result", 32'(result), 0);
    chk("reset tx_data", 32'(TxData), 0);
    chk("reset timeout", 32'(timeout), 0);
    Rst_n = 1'b1;
    @(negedge Clk);

    // Stray strobes in IDLE
    RxData = 8'hFF;
    RxDone = 1'b1;
    TxDone = 1'b1;
    @(negedge Clk);
    RxDone = 1'b0;
    TxDone = 1'b0;
    RxData = 8'h00;
    @(negedge Clk);
    chk("stray result", 32'(result), 0);
    chk("stray done", 32'(done), 0);
    chk("stray busy", 32'(busy), 0);
    chk("stray tx_en", 32'(TxEn), 0);

    // Frame {110,011,101} = 0x19D -> bytes 0x9D, 0x01; response 0x02
    kick(3'b101, 3'b011, 3'b110);
    c0 = cyc;
    chk("t1 busy", 32'(busy), 1);
    chk("t1 tx_data early", 32'(TxData), 32'h9D);
    serve_tx(8'h9D, 1'b0, 1'b0, "t1 b0");
    chk("t1 gap rx_en", 32'(RxEn), 0);
    serve_tx(8'h01, 1'b0, 1'b0, "t1 b1");
    respond(8'h02, "t2");
    chk("t2 done", 32'(done), 1);
    chk("t2 result", 32'(result), 32'h02);
    chk("t2 latency", cyc - c0, 9);
    @(negedge Clk);
    chk("t2 done pulse", 32'(done), 0);
    chk("t2 busy", 32'(busy), 0);
    chk("t2 rx_en", 32'(RxEn), 0);
    chk("t2 result held", 32'(result), 32'h02);

    // Frame {111,000,111} = 0x1C7; start poked during SEND, RxDone collides with TxDone
    kick(3'b111, 3'b000, 3'b111);
    serve_tx(8'hC7, 1'b1, 1'b0, "t3 b0");
    serve_tx(8'h01, 1'b0, 1'b1, "t3 b1");
    chk("t3 collide result", 32'(result), 32'h02);
    chk("t3 collide done", 32'(done), 0);
    chk("t3 collide rx_en", 32'(RxEn), 1);
    respond(8'h01, "t3");
    chk("t3 done", 32'(done), 1);
    chk("t3 result", 32'(result), 32'h01);
    extra_done = 0;
    extra_tx   = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      extra_done += int'(done);
      extra_tx   += int'(TxEn);
    end
    chk("t3 extra done", 32'(extra_done), 0);
    chk("t3 extra tx", 32'(extra_tx), 0);

    // Reset while the second byte is in flight
    kick(3'b101, 3'b011, 3'b110);
    serve_tx(8'h9D, 1'b0, 1'b0, "t4 b0");
    wait_tx_en();
    chk("t4 b1 tx_data", 32'(TxData), 32'h01);
    Rst_n = 1'b0;
    #1;
    chk("t4 rst tx_en", 32'(TxEn), 0);
    chk("t4 rst rx_en", 32'(RxEn), 0);
    chk("t4 rst busy", 32'(busy), 0);
    chk("t4 rst result", 32'(result), 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    kick(3'b101, 3'b011, 3'b110);
    serve_tx(8'h9D, 1'b0, 1'b0, "t4 again b0");
    serve_tx(8'h01, 1'b0, 1'b0, "t4 again b1");
    respond(8'h03, "t4");
    chk("t4 done", 32'(done), 1);
    chk("t4 result", 32'(result), 32'h03);
    @(negedge Clk);

    // Response wait limit
    kick(3'b010, 3'b101, 3'b100);
    serve_tx(8'h2A, 1'b0, 1'b0, "t5 b0");
    serve_tx(8'h01, 1'b0, 1'b0, "t5 b1");
`ifdef RESP_TIMEOUT_EN
    c0  = cyc;
    bad = 0;
    for (int n = 0; n < 40 && timeout !== 1'b1; n++) begin
      @(negedge Clk);
      bad += int'(done);
    end
    chk("t5 timeout", 32'(timeout), 1);
    chk("t5 timeout delay", cyc - c0, 16);
    chk("t5 no done", 32'(bad), 0);
    chk("t5 busy", 32'(busy), 0);
    chk("t5 rx_en", 32'(RxEn), 0);
    @(negedge Clk);
    chk("t5 timeout pulse", 32'(timeout), 0);
    chk("t5 result kept", 32'(result), 32'h03);
    chk("t5 done after", 32'(done), 0);
`else
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge Clk);
      if (RxEn !== 1'b1 || busy !== 1'b1 || timeout !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("t5 long wait", 32'(bad), 0);
    respond(8'h00, "t5");
    chk("t5 done", 32'(done), 1);
    chk("t5 result", 32'(result), 32'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
